ctl_seq: RTL and testbench

Parametrised control sequencer for the pico single-cycle core. It decodes `op_code_i` into PC mode, register-file write enable, ALU operand select and ALU function, as the previous decoder did. It also owns a registered core state machine (RUN / WFI / HALT / ISR) and an N-channel edge-captured, maskable, priority-encoded interrupt unit that vectors the PC into handlers. It sits between instruction fetch (opcode source), the PC unit and the register file/ALU.

---
 rtl/ctl_seq.sv | 213 +++++++++++++++++++++
 tb/tb_ctl_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_seq.sv
// ----------------------------------------------------------------------------
// ctl_seq -- control sequencer for the pico single-cycle core.
//
// Decodes the current opcode into PC mode, register-file write enable, ALU
// operand select and ALU function. Also holds the core state machine
// (RUN / WFI / HALT / ISR) and an N-channel interrupt unit: rising edges are
// captured into pending bits, masked, priority-encoded (lowest index wins)
// and vectored into handlers at VEC_BASE + idx*VEC_STRIDE.
//
// Optional feature macro: PICO_ILLEGAL_TRAP_EN
//   defined   : illegal opcode in RUN traps to VEC_BASE - VEC_STRIDE (ISR)
//   undefined : illegal opcode drives RETURN + halt and parks in HALT
//
// Ports
//   clk_i           core clock
//   rst_i           synchronous, active-high reset
//   op_code_i       current instruction opcode
//   flags_alu_i     ALU flags (only Zero is used)
//   irq_i           level interrupt lines, rising edges captured
//   irq_mask_i      1 = channel enabled
//   mode_pc_o       PC next-address mode
//   wr_en_rf_o      register-file write enable
//   a_imm_alu_o     ALU A operand from immediate
//   func_alu_o      ALU function
//   pc_vec_o        handler address, valid with pc_vec_valid_o
//   pc_vec_valid_o  PC takes pc_vec_o instead of the immediate in SUBROUTINE
//   irq_ack_o       one-hot, one-cycle acknowledge of the taken channel
//   halt_core_o     gate the PC clock permanently
//   wfi_core_o      gate the PC clock while waiting
//   in_isr_o        handler in progress
// ----------------------------------------------------------------------------
package pico_pkg;
    // Bit 4 = immediate form, bit 3 = subtract, bits 2:0 = ALU function.
    // Control opcodes live in the op[3]=1 codes unused by the ALU forms.
    typedef enum logic [4:0] {
        ADD  = 5'b00000, AND  = 5'b00001, OR   = 5'b00010, XOR  = 5'b00011,
        SHL  = 5'b00100, SHR  = 5'b00101, NOT  = 5'b00110, SUB  = 5'b01000,
        ADDI = 5'b10000, ANDI = 5'b10001, ORI  = 5'b10010, XORI = 5'b10011,
        SHLI = 5'b10100, SHRI = 5'b10101, NOTI = 5'b10110, SUBI = 5'b11000,
        BEQ  = 5'b01001, BNE  = 5'b01010, JSBR = 5'b01011, RSBR = 5'b01100,
        WFI  = 5'b01101, HALT = 5'b01110
    } opCode;

    typedef enum logic [2:0] {
        F_ADD, F_AND, F_OR, F_XOR, F_SHL, F_SHR, F_NOT, F_SUB
    } funcALU;

    typedef enum logic [1:0] {
        INCREMENT, RELATIVE, SUBROUTINE, RETURN
    } modePC;

    typedef struct packed {
        logic Neg;
        logic Carry;
        logic Zero;
    } flagsALU;
endpackage

module ctl_seq
    import pico_pkg::*;
#(
    parameter int              N_IRQ      = 4,
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'('h10),
    parameter int              VEC_STRIDE = 4,
    parameter int              DEPTH_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  opCode             op_code_i,
    input  flagsALU           flags_alu_i,
    input  logic [N_IRQ-1:0]  irq_i,
    input  logic [N_IRQ-1:0]  irq_mask_i,
    output modePC             mode_pc_o,
    output logic              wr_en_rf_o,
    output logic              a_imm_alu_o,
    output funcALU            func_alu_o,
    output logic [PC_W-1:0]   pc_vec_o,
    output logic              pc_vec_valid_o,
    output logic [N_IRQ-1:0]  irq_ack_o,
    output logic              halt_core_o,
    output logic              wfi_core_o,
    output logic              in_isr_o
);
    typedef enum logic [1:0] {S_RUN, S_WFI, S_HALT, S_ISR} state_t;

    state_t             state_q, state_d;
    logic [N_IRQ-1:0]   irq_q, pend_q, pend_d, take;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [3:0]         idx;
    logic [4:0]         op_bits;
    logic               unused_flags;

    assign op_bits      = op_code_i;
    assign unused_flags = flags_alu_i.Neg ^ flags_alu_i.Carry;
    assign take         = pend_q & irq_mask_i;
    assign in_isr_o     = (state_q == S_ISR);

    // Lowest enabled pending channel; scanning downward lets the lowest win.
    always_comb begin
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (take[i]) idx = 4'(i);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        mode_pc_o      = INCREMENT;
        wr_en_rf_o     = 1'b0;
        a_imm_alu_o    = op_bits[4];
        func_alu_o     = op_bits[3] ? F_SUB : funcALU'(op_bits[2:0]);
        pc_vec_o       = '0;
        pc_vec_valid_o = 1'b0;
        irq_ack_o      = '0;
        halt_core_o    = 1'b0;
        wfi_core_o     = 1'b0;
        state_d        = state_q;
        depth_d        = depth_q;

        if (state_q == S_HALT) begin
            halt_core_o = 1'b1;
        end else if (state_q != S_ISR && take != '0) begin
            // Entry suppresses the current instruction; the pushed PC is its
            // own address so it re-executes after the handler returns.
            mode_pc_o      = SUBROUTINE;
            pc_vec_valid_o = 1'b1;
            pc_vec_o       = PC_W'(int'(VEC_BASE) + int'(idx) * VEC_STRIDE);
            irq_ack_o      = N_IRQ'(1) << idx;
            state_d        = S_ISR;
        end else if (state_q == S_WFI) begin
            wfi_core_o = 1'b1;
        end else begin
            case (op_code_i)
                ADD, AND, OR, XOR, SHL, SHR, NOT, SUB,
                ADDI, ANDI, ORI, XORI, SHLI, SHRI, NOTI, SUBI: begin
                    wr_en_rf_o = 1'b1;
                end
                BEQ: mode_pc_o = flags_alu_i.Zero ? RELATIVE : INCREMENT;
                BNE: mode_pc_o = flags_alu_i.Zero ? INCREMENT : RELATIVE;
                JSBR: begin
                    mode_pc_o = SUBROUTINE;
                    if (state_q == S_ISR && depth_q != '1) depth_d = depth_q + 1'b1;
                end
                RSBR: begin
                    mode_pc_o = RETURN;
                    if (state_q == S_ISR) begin
                        if (depth_q != '0) depth_d = depth_q - 1'b1;
                        else               state_d = S_RUN;
                    end
                end
                WFI: begin
                    // Inside a handler WFI is a plain NOP.
                    if (state_q == S_RUN) begin
                        wfi_core_o = 1'b1;
                        state_d    = S_WFI;
                    end
                end
                HALT: begin
                    halt_core_o = 1'b1;
                    state_d     = S_HALT;
                end
                default: begin
`ifdef PICO_ILLEGAL_TRAP_EN
                    if (state_q == S_RUN) begin
                        mode_pc_o      = SUBROUTINE;
                        pc_vec_valid_o = 1'b1;
                        pc_vec_o       = PC_W'(int'(VEC_BASE) - VEC_STRIDE);
                        state_d        = S_ISR;
                    end else begin
                        mode_pc_o   = RETURN;
                        halt_core_o = 1'b1;
                        state_d     = S_HALT;
                    end
`else
                    mode_pc_o   = RETURN;
                    halt_core_o = 1'b1;
                    state_d     = S_HALT;
`endif
                end
            endcase
        end

        if (rst_i) begin
            mode_pc_o      = INCREMENT;
            wr_en_rf_o     = 1'b0;
            halt_core_o    = 1'b0;
            wfi_core_o     = 1'b0;
            pc_vec_valid_o = 1'b0;
            irq_ack_o      = '0;
        end
    end

    // A clear from the acknowledge never hides a fresh edge on the same bit.
    assign pend_d = (pend_q & ~irq_ack_o) | (irq_i & ~irq_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            irq_q   <= '0;
            pend_q  <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_i;
            pend_q  <= pend_d;
            depth_q <= depth_d;
        end
    end
endmodule

// File: tb/tb_ctl_seq.sv
// ----------------------------------------------------------------------------
// tb_ctl_seq -- self-checking bench for ctl_seq (default parameters).
// Directed scenarios followed by a randomized run against a behavioural
// model of the sequencer kept in this file. Honors PICO_ILLEGAL_TRAP_EN.
// ----------------------------------------------------------------------------
module tb_ctl_seq;
    import pico_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    opCode      op_code_i;
    flagsALU    flags_alu_i;
    logic [3:0] irq_i, irq_mask_i;
    modePC      mode_pc_o;
    logic       wr_en_rf_o, a_imm_alu_o;
    funcALU     func_alu_o;
    logic [7:0] pc_vec_o;
    logic       pc_vec_valid_o;
    logic [3:0] irq_ack_o;
    logic       halt_core_o, wfi_core_o, in_isr_o;

    int total = 0;
    int bad   = 0;

    opCode  alu_ops  [16] = '{ADD, AND, OR, XOR, SHL, SHR, NOT, SUB,
                              ADDI, ANDI, ORI, XORI, SHLI, SHRI, NOTI, SUBI};
    funcALU alu_func [16] = '{F_ADD, F_AND, F_OR, F_XOR, F_SHL, F_SHR, F_NOT, F_SUB,
                              F_ADD, F_AND, F_OR, F_XOR, F_SHL, F_SHR, F_NOT, F_SUB};
    bit     alu_imm  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    ctl_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_code_i(op_code_i), .flags_alu_i(flags_alu_i),
        .irq_i(irq_i), .irq_mask_i(irq_mask_i), .mode_pc_o(mode_pc_o),
        .wr_en_rf_o(wr_en_rf_o), .a_imm_alu_o(a_imm_alu_o), .func_alu_o(func_alu_o),
        .pc_vec_o(pc_vec_o), .pc_vec_valid_o(pc_vec_valid_o), .irq_ack_o(irq_ack_o),
        .halt_core_o(halt_core_o), .wfi_core_o(wfi_core_o), .in_isr_o(in_isr_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs at the falling edge and let decode settle.
    task automatic apply(input opCode op, input logic zero, input logic [3:0] irq,
                         input logic [3:0] mask);
        @(negedge clk_i);
        op_code_i        = op;
        flags_alu_i      = '0;
        flags_alu_i.Zero = zero;
        irq_i            = irq;
        irq_mask_i       = mask;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        apply(ADD, 1'b0, 4'h0, 4'hF);
        rst_i = 1'b0;
    endtask

    function automatic bit is_alu(input opCode op);
        for (int i = 0; i < 16; i++) if (alu_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (mode_pc_o !== INCREMENT) begin bad++; $display("FAIL rst_mode got=%0d want=%0d", mode_pc_o, INCREMENT); end
        total++; if (wr_en_rf_o !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b want=0", wr_en_rf_o); end
        total++; if ({halt_core_o, wfi_core_o, pc_vec_valid_o} !== 3'b000) begin bad++; $display("FAIL rst_ctl got=%b want=000", {halt_core_o, wfi_core_o, pc_vec_valid_o}); end
        total++; if (irq_ack_o !== 4'h0) begin bad++; $display("FAIL rst_ack got=%b want=0000", irq_ack_o); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b0) begin bad++; $display("FAIL rst_isr got=%b want=0", in_isr_o); end
        rst_i = 1'b0;
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (wr_en_rf_o !== 1'b1) begin bad++; $display("FAIL post_rst_wr got=%b want=1", wr_en_rf_o); end
        total++; if (irq_ack_o !== 4'h0) begin bad++; $display("FAIL post_rst_ack got=%b want=0000", irq_ack_o); end
    endtask

    task automatic test_decode();
        apply(ADDI, 1'b0, 4'h0, 4'hF);
        total++; if (wr_en_rf_o !== 1'b1 || a_imm_alu_o !== 1'b1) begin bad++; $display("FAIL addi_wr_imm got=%b%b want=11", wr_en_rf_o, a_imm_alu_o); end
        total++; if (mode_pc_o !== INCREMENT) begin bad++; $display("FAIL addi_mode got=%0d want=%0d", mode_pc_o, INCREMENT); end
        apply(BNE, 1'b0, 4'h0, 4'hF);
        total++; if (mode_pc_o !== RELATIVE) begin bad++; $display("FAIL bne_z0 got=%0d want=%0d", mode_pc_o, RELATIVE); end
        total++; if (wr_en_rf_o !== 1'b0) begin bad++; $display("FAIL bne_wr got=%b want=0", wr_en_rf_o); end
        apply(BNE, 1'b1, 4'h0, 4'hF);
        total++; if (mode_pc_o !== INCREMENT) begin bad++; $display("FAIL bne_z1 got=%0d want=%0d", mode_pc_o, INCREMENT); end
        apply(BEQ, 1'b1, 4'h0, 4'hF);
        total++; if (mode_pc_o !== RELATIVE) begin bad++; $display("FAIL beq_z1 got=%0d want=%0d", mode_pc_o, RELATIVE); end
        apply(BEQ, 1'b0, 4'h0, 4'hF);
        total++; if (mode_pc_o !== INCREMENT) begin bad++; $display("FAIL beq_z0 got=%0d want=%0d", mode_pc_o, INCREMENT); end
        for (int i = 0; i < 16; i++) begin
            apply(alu_ops[i], 1'($urandom_range(0, 1)), 4'h0, 4'hF);
            total++; if (func_alu_o !== alu_func[i]) begin bad++; $display("FAIL alu_func[%0d] got=%0d want=%0d", i, func_alu_o, alu_func[i]); end
            total++; if (a_imm_alu_o !== alu_imm[i]) begin bad++; $display("FAIL alu_imm[%0d] got=%b want=%b", i, a_imm_alu_o, alu_imm[i]); end
            total++; if (wr_en_rf_o !== 1'b1 || mode_pc_o !== INCREMENT) begin bad++; $display("FAIL alu_ctl[%0d] got=%b/%0d want=1/%0d", i, wr_en_rf_o, mode_pc_o, INCREMENT); end
        end
    endtask

    task automatic test_simultaneous();
        apply(ADD, 1'b0, 4'h0, 4'hF);
        apply(ADD, 1'b0, 4'b0110, 4'hF);
        total++; if (irq_ack_o !== 4'h0) begin bad++; $display("FAIL sim_early_ack got=%b want=0000", irq_ack_o); end
        apply(ADD, 1'b0, 4'b0110, 4'hF);
        total++; if (irq_ack_o !== 4'b0010) begin bad++; $display("FAIL sim_ack1 got=%b want=0010", irq_ack_o); end
        total++; if (pc_vec_o !== 8'h14 || pc_vec_valid_o !== 1'b1) begin bad++; $display("FAIL sim_vec1 got=%h/%b want=14/1", pc_vec_o, pc_vec_valid_o); end
        total++; if (mode_pc_o !== SUBROUTINE || wr_en_rf_o !== 1'b0) begin bad++; $display("FAIL sim_mode1 got=%0d/%b want=%0d/0", mode_pc_o, wr_en_rf_o, SUBROUTINE); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b1 || irq_ack_o !== 4'h0) begin bad++; $display("FAIL sim_nonest got=%b/%b want=1/0000", in_isr_o, irq_ack_o); end
        apply(RSBR, 1'b0, 4'h0, 4'hF);
        total++; if (mode_pc_o !== RETURN) begin bad++; $display("FAIL sim_ret got=%0d want=%0d", mode_pc_o, RETURN); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (irq_ack_o !== 4'b0100 || pc_vec_o !== 8'h18) begin bad++; $display("FAIL sim_ack2 got=%b/%h want=0100/18", irq_ack_o, pc_vec_o); end
        apply(RSBR, 1'b0, 4'h0, 4'hF);
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b0 || irq_ack_o !== 4'h0) begin bad++; $display("FAIL sim_done got=%b/%b want=0/0000", in_isr_o, irq_ack_o); end
    endtask

    task automatic test_wfi();
        for (int i = 0; i < 5; i++) begin
            apply(WFI, 1'b0, 4'h0, 4'hF);
            total++; if (wfi_core_o !== 1'b1 || wr_en_rf_o !== 1'b0 || mode_pc_o !== INCREMENT) begin bad++; $display("FAIL wfi_wait[%0d] got=%b%b/%0d want=10/%0d", i, wfi_core_o, wr_en_rf_o, mode_pc_o, INCREMENT); end
        end
        apply(WFI, 1'b0, 4'h1, 4'hF);
        total++; if (wfi_core_o !== 1'b1 || irq_ack_o !== 4'h0) begin bad++; $display("FAIL wfi_edge got=%b/%b want=1/0000", wfi_core_o, irq_ack_o); end
        apply(WFI, 1'b0, 4'h1, 4'hF);
        total++; if (wfi_core_o !== 1'b0 || pc_vec_o !== 8'h10 || irq_ack_o !== 4'h1) begin bad++; $display("FAIL wfi_wake got=%b/%h/%b want=0/10/0001", wfi_core_o, pc_vec_o, irq_ack_o); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b1 || wfi_core_o !== 1'b0) begin bad++; $display("FAIL wfi_isr got=%b/%b want=1/0", in_isr_o, wfi_core_o); end
        apply(RSBR, 1'b0, 4'h0, 4'hF);
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b0) begin bad++; $display("FAIL wfi_ret got=%b want=0", in_isr_o); end
    endtask

    task automatic test_depth();
        opCode seq   [4] = '{JSBR, JSBR, RSBR, RSBR};
        modePC modes [4] = '{SUBROUTINE, SUBROUTINE, RETURN, RETURN};
        apply(ADD, 1'b0, 4'h8, 4'hF);
        apply(ADD, 1'b0, 4'h8, 4'hF);
        total++; if (irq_ack_o !== 4'b1000 || pc_vec_o !== 8'h1C) begin bad++; $display("FAIL dep_entry got=%b/%h want=1000/1c", irq_ack_o, pc_vec_o); end
        for (int i = 0; i < 4; i++) begin
            apply(seq[i], 1'b0, 4'h0, 4'hF);
            total++; if (mode_pc_o !== modes[i] || in_isr_o !== 1'b1) begin bad++; $display("FAIL dep_seq[%0d] got=%0d/%b want=%0d/1", i, mode_pc_o, in_isr_o, modes[i]); end
        end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b1) begin bad++; $display("FAIL dep_hold got=%b want=1", in_isr_o); end
        apply(RSBR, 1'b0, 4'h0, 4'hF);
        total++; if (mode_pc_o !== RETURN) begin bad++; $display("FAIL dep_ret got=%0d want=%0d", mode_pc_o, RETURN); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b0) begin bad++; $display("FAIL dep_exit got=%b want=0", in_isr_o); end
    endtask

    task automatic test_halt();
        apply(HALT, 1'b0, 4'h0, 4'hF);
        total++; if (halt_core_o !== 1'b1) begin bad++; $display("FAIL halt_op got=%b want=1", halt_core_o); end
        for (int i = 0; i < 10; i++) begin
            apply(ADD, 1'b0, (i % 2 == 1) ? 4'hF : 4'h0, 4'hF);
            total++; if (halt_core_o !== 1'b1 || wr_en_rf_o !== 1'b0 || mode_pc_o !== INCREMENT || irq_ack_o !== 4'h0) begin bad++; $display("FAIL halt_hold[%0d] got=%b%b/%0d/%b want=10/%0d/0000", i, halt_core_o, wr_en_rf_o, mode_pc_o, irq_ack_o, INCREMENT); end
        end
        rst_i = 1'b1;
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (halt_core_o !== 1'b0) begin bad++; $display("FAIL halt_rst_force got=%b want=0", halt_core_o); end
        rst_i = 1'b0;
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (halt_core_o !== 1'b0 || wr_en_rf_o !== 1'b1 || irq_ack_o !== 4'h0) begin bad++; $display("FAIL halt_exit got=%b%b/%b want=01/0000", halt_core_o, wr_en_rf_o, irq_ack_o); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (irq_ack_o !== 4'h0 || in_isr_o !== 1'b0) begin bad++; $display("FAIL halt_pend_clr got=%b/%b want=0000/0", irq_ack_o, in_isr_o); end
    endtask

    task automatic test_illegal();
        opCode ill = opCode'(5'b11111);
        apply(ill, 1'b0, 4'h0, 4'hF);
`ifdef PICO_ILLEGAL_TRAP_EN
        total++; if (mode_pc_o !== SUBROUTINE || pc_vec_valid_o !== 1'b1 || pc_vec_o !== 8'h0C) begin bad++; $display("FAIL ill_trap got=%0d/%b/%h want=%0d/1/0c", mode_pc_o, pc_vec_valid_o, pc_vec_o, SUBROUTINE); end
        total++; if (irq_ack_o !== 4'h0 || wr_en_rf_o !== 1'b0) begin bad++; $display("FAIL ill_trap_ack got=%b/%b want=0000/0", irq_ack_o, wr_en_rf_o); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (in_isr_o !== 1'b1) begin bad++; $display("FAIL ill_trap_isr got=%b want=1", in_isr_o); end
        apply(RSBR, 1'b0, 4'h0, 4'hF);
`else
        total++; if (halt_core_o !== 1'b1 || mode_pc_o !== RETURN) begin bad++; $display("FAIL ill_halt got=%b/%0d want=1/%0d", halt_core_o, mode_pc_o, RETURN); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (halt_core_o !== 1'b1) begin bad++; $display("FAIL ill_halt_hold got=%b want=1", halt_core_o); end
        do_reset();
`endif
        apply(ADD, 1'b0, 4'h1, 4'hF);
        apply(ADD, 1'b0, 4'h1, 4'hF);
        apply(ill, 1'b0, 4'h0, 4'hF);
        total++; if (halt_core_o !== 1'b1) begin bad++; $display("FAIL ill_isr got=%b want=1", halt_core_o); end
        apply(ADD, 1'b0, 4'h0, 4'hF);
        total++; if (halt_core_o !== 1'b1 || in_isr_o !== 1'b0) begin bad++; $display("FAIL ill_isr_halt got=%b/%b want=1/0", halt_core_o, in_isr_o); end
        do_reset();
    endtask

    task automatic test_random();
        bit [3:0] m_pend = '0, m_prev = '0;
        bit       m_isr = 1'b0, m_wfi = 1'b0, m_halt = 1'b0;
        int       m_depth = 0, halt_age = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            opCode op; logic z; logic [3:0] irq, mask, take, e_ack;
            modePC e_mode; logic e_wr, e_valid, e_halt, e_wfi, e_isr; logic [7:0] e_vec;
            int r, low;
            if (m_halt && halt_age >= 3) begin
                do_reset();
                m_pend = '0; m_prev = '0; m_isr = 0; m_wfi = 0; m_halt = 0; m_depth = 0;
                continue;
            end
            r  = $urandom_range(0, 99);
            op = (r < 40) ? alu_ops[$urandom_range(0, 15)] : (r < 52) ? BEQ : (r < 64) ? BNE :
                 (r < 78) ? JSBR : (r < 92) ? RSBR : (r < 98) ? WFI : HALT;
            z    = 1'($urandom_range(0, 1));
            irq  = m_prev ^ (($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
            mask = 4'($urandom_range(0, 15));
            apply(op, z, irq, mask);

            take = m_pend & mask;
            low  = -1;
            for (int i = 0; i < 4; i++) if (take[i] && low < 0) low = i;
            e_mode = INCREMENT; e_wr = 0; e_valid = 0; e_vec = '0; e_ack = '0;
            e_halt = 0; e_wfi = 0; e_isr = m_isr;
            if (m_halt) begin
                e_halt = 1; halt_age++;
            end else if (!m_isr && low >= 0) begin
                e_mode = SUBROUTINE; e_valid = 1; e_vec = 8'(16 + 4 * low); e_ack = 4'(1 << low);
                m_isr = 1; m_wfi = 0; m_depth = 0;
            end else if (m_wfi) begin
                e_wfi = 1;
            end else if (is_alu(op)) begin
                e_wr = 1;
            end else begin
                case (op)
                    BEQ:  e_mode = z ? RELATIVE : INCREMENT;
                    BNE:  e_mode = z ? INCREMENT : RELATIVE;
                    JSBR: begin e_mode = SUBROUTINE; if (m_isr && m_depth < 7) m_depth++; end
                    RSBR: begin
                        e_mode = RETURN;
                        if (m_isr) begin if (m_depth > 0) m_depth--; else m_isr = 0; end
                    end
                    WFI:  if (!m_isr) begin e_wfi = 1; m_wfi = 1; end
                    HALT: begin e_halt = 1; m_halt = 1; m_isr = 0; halt_age = 0; end
                    default: ;
                endcase
            end
            total++; if (mode_pc_o !== e_mode) begin bad++; $display("FAIL rnd_mode c=%0d op=%0d got=%0d want=%0d", c, op, mode_pc_o, e_mode); end
            total++; if (wr_en_rf_o !== e_wr) begin bad++; $display("FAIL rnd_wr c=%0d got=%b want=%b", c, wr_en_rf_o, e_wr); end
            total++; if (pc_vec_valid_o !== e_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, pc_vec_valid_o, e_valid); end
            if (e_valid) begin
                total++; if (pc_vec_o !== e_vec) begin bad++; $display("FAIL rnd_vec c=%0d got=%h want=%h", c, pc_vec_o, e_vec); end
            end
            total++; if (irq_ack_o !== e_ack) begin bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, irq_ack_o, e_ack); end
            total++; if (halt_core_o !== e_halt || wfi_core_o !== e_wfi) begin bad++; $display("FAIL rnd_gate c=%0d got=%b%b want=%b%b", c, halt_core_o, wfi_core_o, e_halt, e_wfi); end
            total++; if (in_isr_o !== e_isr) begin bad++; $display("FAIL rnd_isr c=%0d got=%b want=%b", c, in_isr_o, e_isr); end
            m_pend = (m_pend & ~e_ack) | (irq & ~m_prev);
            m_prev = irq;
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        op_code_i   = ADD;
        flags_alu_i = '0;
        irq_i       = 4'h0;
        irq_mask_i  = 4'h0;
        test_reset();
        test_decode();
        test_simultaneous();
        test_wfi();
        test_depth();
        test_halt();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
